// File: rtl/ycr_arb_rr.sv
// ycr_arb_rr: N-way round-robin arbiter with per-grant burst quantum and indexed/one-hot grants.
// Optional hung-target watchdog (wdog_err pulse) is built when YCR_ARB_WDOG_EN is defined.

module ycr_arb_rr_lane #(
    parameter int IDX = 0,
    parameter int GW  = 3
) (
    input  logic [GW-1:0] ptr,
    input  logic          req,
    output logic          hi
);
    // Requester sits at or above the rotating pointer: it wins over any wrapped candidate.
    assign hi = req && (ptr <= GW'(IDX));
endmodule

module ycr_arb_rr #(
    parameter  int N_REQ       = 8,
    parameter  int QUANTUM     = 1,
    parameter  int WDOG_CYCLES = 256,
    localparam int GW          = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             req_ack,
    input  logic             lack,
    output logic             gnt_vld,
    output logic [GW-1:0]    gnt_id,
    output logic [N_REQ-1:0] gnt_oh
`ifdef YCR_ARB_WDOG_EN
   ,output logic             wdog_err
`endif
);

    localparam int QW = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;

    typedef enum logic [1:0] {
        ARB       = 2'd0,
        WAIT_ACK  = 2'd1,
        WAIT_LACK = 2'd2
    } state_t;

    state_t           state;
    logic [GW-1:0]    ptr;
    logic [QW-1:0]    qcnt;
    logic [N_REQ-1:0] hi;
    logic [GW-1:0]    sel_id;
    logic             sel_vld;
    logic [GW-1:0]    ptr_nxt;
    logic             cont, done, to_lack, abort, wdog_hit;

    for (genvar g = 0; g < N_REQ; g++) begin : g_lane
        ycr_arb_rr_lane #(.IDX(g), .GW(GW)) u_lane (
            .ptr (ptr),
            .req (req[g]),
            .hi  (hi[g])
        );
    end

    // Lowest index at/after ptr wins; otherwise lowest index overall (the wrapped part).
    always_comb begin
        sel_vld = |req;
        sel_id  = '0;
        for (int i = N_REQ - 1; i >= 0; i--) if (req[i]) sel_id = GW'(i);
        for (int i = N_REQ - 1; i >= 0; i--) if (hi[i])  sel_id = GW'(i);
    end

    assign ptr_nxt = (gnt_id == GW'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
    assign cont    = req[gnt_id] && (32'(qcnt) < 32'(QUANTUM - 1));
    assign done    = ((state == WAIT_ACK) && req_ack && lack) || ((state == WAIT_LACK) && lack);
    assign to_lack = (state == WAIT_ACK) && req_ack && !lack;
    assign abort   = (state == WAIT_ACK) && !req_ack && !req[gnt_id];

`ifdef YCR_ARB_WDOG_EN
    localparam int WW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
    logic [WW-1:0] wcnt;

    assign wdog_hit = ((state == WAIT_ACK) || (state == WAIT_LACK)) &&
                      (wcnt == WW'(WDOG_CYCLES - 1)) && !done && !to_lack && !abort;
`else
    logic unused_wdog;
    assign unused_wdog = (WDOG_CYCLES > 0);
    assign wdog_hit    = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ARB;
            ptr     <= '0;
            qcnt    <= '0;
            gnt_vld <= 1'b0;
            gnt_id  <= '0;
            gnt_oh  <= '0;
`ifdef YCR_ARB_WDOG_EN
            wcnt     <= '0;
            wdog_err <= 1'b0;
`endif
        end else begin
`ifdef YCR_ARB_WDOG_EN
            wdog_err <= 1'b0;
`endif
            case (state)
                ARB: begin
`ifdef YCR_ARB_WDOG_EN
                    wcnt <= '0;
`endif
                    if (sel_vld) begin
                        gnt_vld <= 1'b1;
                        gnt_id  <= sel_id;
                        gnt_oh  <= N_REQ'(1) << sel_id;
                        qcnt    <= '0;
                        state   <= WAIT_ACK;
                    end else begin
                        gnt_vld <= 1'b0;
                        gnt_oh  <= '0;
                    end
                end
                WAIT_ACK, WAIT_LACK: begin
`ifdef YCR_ARB_WDOG_EN
                    wcnt <= wcnt + 1'b1;
                    if (done || to_lack || abort || wdog_hit) wcnt <= '0;
                    wdog_err <= wdog_hit;
`endif
                    if (done && cont) begin
                        // Burst continuation: same requester keeps the port.
                        qcnt  <= qcnt + 1'b1;
                        state <= WAIT_ACK;
                    end else if (done || wdog_hit) begin
                        gnt_vld <= 1'b0;
                        gnt_oh  <= '0;
                        ptr     <= ptr_nxt;
                        qcnt    <= '0;
                        state   <= ARB;
                    end else if (to_lack) begin
                        state <= WAIT_LACK;
                    end else if (abort) begin
                        gnt_vld <= 1'b0;
                        gnt_oh  <= '0;
                        state   <= ARB;
                    end
                end
                default: begin
                    gnt_vld <= 1'b0;
                    gnt_oh  <= '0;
                    state   <= ARB;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ycr_arb_rr.sv
// Directed bench for ycr_arb_rr: three instances (8x1, 5x1, 8x3 quantum) with a grant-id scoreboard.
// Watchdog timing is exercised only when YCR_ARB_WDOG_EN is defined.

module tb_ycr_arb_rr;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [7:0] req0, req2, goh0, goh2;
    logic [4:0] req1, goh1;
    logic [2:0] ack, lk, gid0, gid1, gid2;
    logic       gv0, gv1, gv2;
`ifdef YCR_ARB_WDOG_EN
    logic       we0, we1, we2;
`endif

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    ycr_arb_rr #(.N_REQ(8), .QUANTUM(1), .WDOG_CYCLES(16)) u_dut0 (
        .clk(clk), .rst(rst), .req(req0), .req_ack(ack[0]), .lack(lk[0]),
        .gnt_vld(gv0), .gnt_id(gid0), .gnt_oh(goh0)
`ifdef YCR_ARB_WDOG_EN
       ,.wdog_err(we0)
`endif
    );
    ycr_arb_rr #(.N_REQ(5), .QUANTUM(1), .WDOG_CYCLES(256)) u_dut1 (
        .clk(clk), .rst(rst), .req(req1), .req_ack(ack[1]), .lack(lk[1]),
        .gnt_vld(gv1), .gnt_id(gid1), .gnt_oh(goh1)
`ifdef YCR_ARB_WDOG_EN
       ,.wdog_err(we1)
`endif
    );
    ycr_arb_rr #(.N_REQ(8), .QUANTUM(3), .WDOG_CYCLES(256)) u_dut2 (
        .clk(clk), .rst(rst), .req(req2), .req_ack(ack[2]), .lack(lk[2]),
        .gnt_vld(gv2), .gnt_id(gid2), .gnt_oh(goh2)
`ifdef YCR_ARB_WDOG_EN
       ,.wdog_err(we2)
`endif
    );

    logic [2:0]  vv;
    logic [31:0] vid[3];
    logic [31:0] voh[3];
    always_comb begin
        vv     = {gv2, gv1, gv0};
        vid[0] = 32'(gid0); vid[1] = 32'(gid1); vid[2] = 32'(gid2);
        voh[0] = 32'(goh0); voh[1] = 32'(goh1); voh[2] = 32'(goh2);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a grant on instance k and compare it with the scoreboard head.
    task automatic grant(input int k, input string tag);
        int n;
        logic [31:0] e;
        n = 0;
        while (!vv[k] && n < 20) begin
            tick();
            n++;
        end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
        chk({tag, " vld"}, 32'(vv[k]), 32'd1);
        chk({tag, " id"}, vid[k], e);
        chk({tag, " oh"}, voh[k], 32'd1 << e);
    endtask

    // One transaction: ack, then lack `gap` cycles after the ack cycle (0 = same cycle).
    task automatic xfer(input int k, input int gap);
        ack[k] = 1'b1;
        lk[k]  = (gap == 0);
        tick();
        ack[k] = 1'b0;
        lk[k]  = 1'b0;
        if (gap > 0) begin
            repeat (gap - 1) tick();
            lk[k] = 1'b1;
            tick();
            lk[k] = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        req0 = '0; req1 = '0; req2 = '0; ack = '0; lk = '0;
        tick();
        chk("rst vld0", 32'(gv0), 0);
        chk("rst id0", vid[0], 0);
        chk("rst oh0", voh[0], 0);
        chk("rst oh1", voh[1], 0);
        chk("rst oh2", voh[2], 0);
`ifdef YCR_ARB_WDOG_EN
        chk("rst wdog", 32'({we2, we1, we0}), 0);
`endif
        rst = 1'b0;
        tick(); tick();
        chk("idle vld", 32'(vv), 0);

        // Strict round robin with all requesters active
        req0 = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(32'(i));
            grant(0, "rr");
            xfer(0, 2);
            chk("rr release", 32'(gv0), 0);
        end
        exp_q.push_back(0);
        grant(0, "rr wrap");
        ack[0] = 1'b1; tick(); ack[0] = 1'b0;
        req0 = '0;
        lk[0] = 1'b1; tick(); lk[0] = 1'b0;
        tick();
        chk("rr idle", 32'(gv0), 0);

        // N_REQ=5: ptr=4 after granting 3, then wrap to 0
        req1 = 5'b01000;
        exp_q.push_back(3);
        grant(1, "n5 a");
        ack[1] = 1'b1; tick(); ack[1] = 1'b0;
        req1 = 5'b10001;
        tick();
        chk("n5 hold vld", 32'(gv1), 1);
        chk("n5 hold id", vid[1], 3);
        lk[1] = 1'b1; tick(); lk[1] = 1'b0;
        exp_q.push_back(4);
        grant(1, "n5 b");
        xfer(1, 2);
        exp_q.push_back(0);
        grant(1, "n5 wrap");
        xfer(1, 2);
        exp_q.push_back(4);
        grant(1, "n5 c");
        ack[1] = 1'b1; tick(); ack[1] = 1'b0;
        req1 = '0;
        lk[1] = 1'b1; tick(); lk[1] = 1'b0;

        // QUANTUM=3 burst on 2, then 5
        req2 = 8'b0010_0100;
        exp_q.push_back(2); exp_q.push_back(2); exp_q.push_back(2); exp_q.push_back(5);
        for (int i = 0; i < 3; i++) begin
            grant(2, "q3 burst");
            xfer(2, 1);
        end
        grant(2, "q3 next");
        req2 = '0;
        tick();
        chk("q3 abort", 32'(gv2), 0);

        // Abort on dut0: ptr is 1 and must stay 1
        req0 = 8'b0000_0010;
        exp_q.push_back(1);
        grant(0, "abort");
        req0 = '0;
        tick();
        chk("abort vld", 32'(gv0), 0);
        chk("abort oh", voh[0], 0);
        req0 = 8'b0000_0011;
        exp_q.push_back(1);
        grant(0, "post abort");

        // Zero-wait completion in the first WAIT_ACK cycle, ptr -> 2
        req0 = 8'b0000_0111;
        xfer(0, 0);
        chk("zw release", 32'(gv0), 0);
        exp_q.push_back(2);
        grant(0, "zw next");
        req0 = '0;
        xfer(0, 0);
        chk("zw release2", 32'(gv0), 0);

`ifdef YCR_ARB_WDOG_EN
        // Watchdog: ack with no lack, pulse 16 cycles after entering WAIT_LACK
        begin
            int n;
            req0 = 8'b0001_0000;
            exp_q.push_back(4);
            grant(0, "wd");
            ack[0] = 1'b1; tick(); ack[0] = 1'b0;
            n = 0;
            while (!we0 && n < 40) begin
                tick();
                n++;
            end
            chk("wd delay", 32'(n), 16);
            chk("wd vld", 32'(gv0), 0);
            tick();
            chk("wd pulse", 32'(we0), 0);
        end
        exp_q.push_back(4);
`else
        req0 = 8'b0001_0000;
        exp_q.push_back(4);
`endif
        // Async reset mid-transaction drops everything before the next edge
        grant(0, "pre rst");
        ack[0] = 1'b1; tick(); ack[0] = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        chk("arst vld", 32'(gv0), 0);
        chk("arst id", vid[0], 0);
        chk("arst oh", voh[0], 0);
`ifdef YCR_ARB_WDOG_EN
        chk("arst wdog", 32'(we0), 0);
`endif
        req0 = '0;
        tick();
        rst = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
